// File: rtl/complex_accum_fp32.sv
// Streaming fp32 complex accumulator: ADD_LAT interleaved partial sums per lane circulate
// through the adder pipeline, are drained in slot order, then pairwise tree-reduced.
module complex_accum_fp32 #(
  parameter int unsigned ADD_LAT = 11,
  parameter int unsigned LEN_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [63:0]      in,
  output logic             in_ready,
  output logic [63:0]      out,
  output logic             out_valid,
  output logic             busy
);

  localparam int unsigned PtrW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
  localparam int unsigned RcW  = $clog2(2 * ADD_LAT + 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(ADD_LAT - 1);
  localparam logic [RcW-1:0]  LatR    = RcW'(ADD_LAT);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccum  = 2'd1;
  localparam logic [1:0] StDrain  = 2'd2;
  localparam logic [1:0] StReduce = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d, cnt_q, cnt_d, cnt_inc;
  logic [PtrW-1:0]    ptr_q, ptr_d, ptr_inc;
  logic [ADD_LAT-1:0] vld_q, vld_d;
  logic [RcW-1:0]     n_q, n_d, rc_q, rc_d, half, n_next;
  logic               round_last;
  logic [63:0]        out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic [63:0]        part_q [ADD_LAT];
  logic [63:0]        part_d [ADD_LAT];
  logic [31:0]        pipe_re_q [ADD_LAT];
  logic [31:0]        pipe_im_q [ADD_LAT];
  logic [63:0]        op_a, op_b, sum;
  logic               accept;

  // Truncating fp32 add: denormals treated as zero, overflow saturates to infinity.
  function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
    logic [31:0]       big, sml, res;
    logic [7:0]        sh;
    logic [26:0]       mb, ms, ms_al, mask, mag;
    logic [27:0]       tot;
    logic              sticky, found;
    logic [4:0]        lz;
    logic signed [9:0] e_res;
    big = '0; sml = '0; res = '0; sh = '0; mb = '0; ms = '0; ms_al = '0; mask = '0;
    mag = '0; tot = '0; sticky = 1'b0; found = 1'b0; lz = '0; e_res = '0;
    if (x[30:23] == 8'hff) begin
      res = {x[31], 8'hff, 23'd0};
    end else if (y[30:23] == 8'hff) begin
      res = {y[31], 8'hff, 23'd0};
    end else if (x[30:23] == 8'd0 && y[30:23] == 8'd0) begin
      res = '0;
    end else if (x[30:23] == 8'd0) begin
      res = y;
    end else if (y[30:23] == 8'd0) begin
      res = x;
    end else begin
      if (x[30:0] >= y[30:0]) begin
        big = x;
        sml = y;
      end else begin
        big = y;
        sml = x;
      end
      sh = big[30:23] - sml[30:23];
      mb = {1'b1, big[22:0], 3'b000};
      ms = {1'b1, sml[22:0], 3'b000};
      if (sh > 8'd26) begin
        ms_al  = '0;
        sticky = 1'b1;
      end else begin
        mask   = ~(27'h7ffffff << sh);
        ms_al  = ms >> sh;
        sticky = |(ms & mask);
      end
      // Sticky keeps effective subtraction from rounding up through truncation.
      ms_al[0] = ms_al[0] | sticky;
      if (big[31] == sml[31]) tot = {1'b0, mb} + {1'b0, ms_al};
      else                    tot = {1'b0, mb} - {1'b0, ms_al};
      if (tot == '0) begin
        res = '0;
      end else if (tot[27]) begin
        if (big[30:23] == 8'hfe) res = {big[31], 8'hff, 23'd0};
        else                     res = {big[31], big[30:23] + 8'd1, tot[26:4]};
      end else begin
        mag = tot[26:0];
        for (int i = 26; i >= 0; i--) begin
          if (!found) begin
            if (mag[i]) found = 1'b1;
            else        lz = lz + 5'd1;
          end
        end
        mag   = mag << lz;
        e_res = $signed({2'b00, big[30:23]}) - $signed({5'd0, lz});
        if (e_res <= 0) res = '0;
        else            res = {big[31], e_res[7:0], mag[25:3]};
      end
    end
    return res;
  endfunction

  assign sum        = {pipe_re_q[ADD_LAT-1], pipe_im_q[ADD_LAT-1]};
  assign accept     = in_valid && in_ready;
  assign cnt_inc    = cnt_q + LEN_W'(1);
  assign ptr_inc    = (ptr_q == PtrLast) ? '0 : ptr_q + PtrW'(1);
  assign half       = n_q >> 1;
  assign n_next     = half + {{(RcW-1){1'b0}}, n_q[0]};
  assign round_last = (rc_q == half + LatR - RcW'(1));

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    vld_d       = vld_q;
    n_d         = n_q;
    rc_d        = rc_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    part_d      = part_q;
    op_a        = '0;
    op_b        = '0;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (len != '0) begin
            len_d   = len;
            cnt_d   = '0;
            ptr_d   = '0;
            vld_d   = '0;
            state_d = StAccum;
          end else begin
            out_d       = '0;
            out_valid_d = 1'b1;
          end
        end
      end
      StAccum: begin
        // Slots never issued yet feed +0 back instead of stale pipeline contents.
        if (accept)        op_a = in;
        if (vld_q[ptr_q])  op_b = sum;
        vld_d[ptr_q] = 1'b1;
        ptr_d        = ptr_inc;
        if (accept) begin
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = StDrain;
            rc_d    = '0;
          end
        end
      end
      StDrain: begin
        part_d[ptr_q] = vld_q[ptr_q] ? sum : '0;
        ptr_d         = ptr_inc;
        rc_d          = rc_q + RcW'(1);
        if (rc_q == LatR - RcW'(1)) begin
          state_d = StReduce;
          rc_d    = '0;
          n_d     = LatR;
        end
      end
      default: begin
        if (rc_q < half) begin
          op_a = part_q[PtrW'({rc_q, 1'b0})];
          op_b = part_q[PtrW'({rc_q, 1'b1})];
        end
        if (rc_q >= LatR) part_d[PtrW'(rc_q - LatR)] = sum;
        if (round_last) begin
          // All pair reads finished long ago, so the odd leftover can move down now.
          if (n_q[0]) part_d[PtrW'(half)] = part_q[PtrW'(n_q - RcW'(1))];
          n_d  = n_next;
          rc_d = '0;
          if (n_next == RcW'(1)) begin
            state_d     = StIdle;
            out_d       = sum;
            out_valid_d = 1'b1;
          end
        end else begin
          rc_d = rc_q + RcW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      len_q       <= '0;
      cnt_q       <= '0;
      ptr_q       <= '0;
      vld_q       <= '0;
      n_q         <= '0;
      rc_q        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      vld_q       <= vld_d;
      n_q         <= n_d;
      rc_q        <= rc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Datapath carries no reset; validity lives entirely in the control counters above.
  always_ff @(posedge clk) begin
    pipe_re_q[0] <= fp_add(op_a[63:32], op_b[63:32]);
    pipe_im_q[0] <= fp_add(op_a[31:0], op_b[31:0]);
    for (int k = 1; k < ADD_LAT; k++) begin
      pipe_re_q[k] <= pipe_re_q[k-1];
      pipe_im_q[k] <= pipe_im_q[k-1];
    end
    part_q <= part_d;
  end

  assign in_ready  = (state_q == StAccum);
  assign busy      = (state_q != StIdle);
  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_complex_accum_fp32.sv
// Bench for complex_accum_fp32: directed scenarios plus randomized integer-valued streams
// whose exact sums are modelled with plain integer arithmetic.
module tb_complex_accum_fp32;
  localparam int unsigned AddLat = 11;
  localparam int unsigned LenW   = 16;
  localparam int          ExpLat = 66;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [LenW-1:0] len;
  logic            in_valid;
  logic [63:0]     in_data;
  logic            in_ready;
  logic [63:0]     out_data;
  logic            out_valid;
  logic            busy;

  int total_cnt = 0;
  int pass_cnt  = 0;

  complex_accum_fp32 #(
    .ADD_LAT(AddLat),
    .LEN_W  (LenW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in       (in_data),
    .in_ready (in_ready),
    .out      (out_data),
    .out_valid(out_valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Exact fp32 encoding of an integer with magnitude below 2^24.
  function automatic logic [31:0] int_to_fp(input int v);
    int unsigned m;
    int          p;
    logic [31:0] r;
    if (v == 0) return 32'h0;
    m = (v < 0) ? -v : v;
    p = 0;
    for (int b = 0; b < 32; b++) if (m[b]) p = b;
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + p);
    r[22:0]  = 23'(m << (23 - p));
    return r;
  endfunction

  // Starts an accumulation of s.size() samples, feeds them with 'gap' idle cycles between,
  // optionally pulses start on sample poke_idx, then waits (bounded) for out_valid.
  task automatic run_op(input logic [63:0] s[$], input int gap, input int poke_idx,
                        output int lat, output logic rdy_after, output logic [63:0] res);
    int guard;
    int k;
    lat = -1;
    rdy_after = 1'b1;
    res = '0;
    @(negedge clk);
    start = 1'b1;
    len   = LenW'(s.size());
    @(negedge clk);
    start = 1'b0;
    foreach (s[i]) begin
      in_valid = 1'b1;
      in_data  = s[i];
      if (i == poke_idx) begin
        start = 1'b1;
        len   = 3;
      end
      guard = 0;
      while (!in_ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      if (!in_ready) begin
        total_cnt++;
        $display("FAIL accept_timeout: in_ready got 0 required 1 at sample %0d", i);
        in_valid = 1'b0;
        start    = 1'b0;
        return;
      end
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
      if (i == s.size() - 1) rdy_after = in_ready;
      else repeat (gap) @(negedge clk);
    end
    k = 1;
    while (!out_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (out_valid) begin
      lat = k;
      res = out_data;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0;
    #3;
    total_cnt++;
    if ({in_ready, busy, out_valid} !== 3'b000)
      $display("FAIL reset_flags: got %b required 000", {in_ready, busy, out_valid});
    else pass_cnt++;
    total_cnt++;
    if (out_data !== 64'h0) $display("FAIL reset_out: got %h required 0", out_data);
    else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [63:0] s[$];
    int lat;
    logic rdy;
    logic [63:0] res;
    s.push_back(64'h3F800000_C0000000);
    run_op(s, 0, -1, lat, rdy, res);
    total_cnt++;
    if (res !== 64'h3F800000_C0000000) $display("FAIL single_out: got %h required %h", res,
                                                64'h3F800000_C0000000);
    else pass_cnt++;
    total_cnt++;
    if (lat !== ExpLat) $display("FAIL single_latency: got %0d required %0d", lat, ExpLat);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({out_valid, busy} !== 2'b00 || out_data !== 64'h3F800000_C0000000)
      $display("FAIL single_hold: got v=%b b=%b out=%h required v=0 b=0 out=%h", out_valid,
               busy, out_data, 64'h3F800000_C0000000);
    else pass_cnt++;
  endtask

  task automatic test_zero_len();
    @(negedge clk);
    start = 1'b1;
    len   = '0;
    @(negedge clk);
    start = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b1 || out_data !== 64'h0 || busy !== 1'b0)
      $display("FAIL zero_len_done: got v=%b out=%h b=%b required v=1 out=0 b=0", out_valid,
               out_data, busy);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL zero_len_pulse: got v=%b b=%b required v=0 b=0", out_valid, busy);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back(input int poke_idx);
    logic [63:0] s[$];
    int lat;
    logic rdy;
    logic [63:0] res;
    for (int i = 0; i < 16; i++) s.push_back(64'h3F800000_3F800000);
    run_op(s, 0, poke_idx, lat, rdy, res);
    total_cnt++;
    if (res !== 64'h41800000_41800000) $display("FAIL b2b_out: got %h required %h", res,
                                                64'h41800000_41800000);
    else pass_cnt++;
    total_cnt++;
    if (rdy !== 1'b0) $display("FAIL b2b_ready_drop: got %b required 0", rdy);
    else pass_cnt++;
    total_cnt++;
    if (lat !== ExpLat) $display("FAIL b2b_latency: got %0d required %0d", lat, ExpLat);
    else pass_cnt++;
  endtask

  task automatic test_gapped();
    logic [63:0] s[$];
    int lat;
    logic rdy;
    logic [63:0] res;
    for (int i = 1; i <= 5; i++) s.push_back({int_to_fp(i), 32'h0});
    run_op(s, 2, -1, lat, rdy, res);
    total_cnt++;
    if (res !== 64'h41700000_00000000) $display("FAIL gapped_out: got %h required %h", res,
                                                64'h41700000_00000000);
    else pass_cnt++;
    total_cnt++;
    if (lat !== ExpLat) $display("FAIL gapped_latency: got %0d required %0d", lat, ExpLat);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [63:0] s[$];
    int lat;
    logic rdy;
    logic [63:0] res;
    @(negedge clk);
    start = 1'b1;
    len   = 8;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = {int_to_fp(i + 1), int_to_fp(7)};
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    total_cnt++;
    if ({in_ready, busy, out_valid} !== 3'b000 || out_data !== 64'h0)
      $display("FAIL reset_mid_abort: got rdy=%b b=%b v=%b out=%h required all 0", in_ready,
               busy, out_valid, out_data);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    s.push_back(64'h40000000_40400000);
    s.push_back(64'h40000000_40400000);
    run_op(s, 0, -1, lat, rdy, res);
    total_cnt++;
    if (res !== 64'h40800000_40C00000) $display("FAIL reset_mid_out: got %h required %h", res,
                                                64'h40800000_40C00000);
    else pass_cnt++;
    total_cnt++;
    if (lat !== ExpLat) $display("FAIL reset_mid_latency: got %0d required %0d", lat, ExpLat);
    else pass_cnt++;
  endtask

  task automatic test_ignored();
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 64'h447A0000_447A0000;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({in_ready, busy} !== 2'b00)
      $display("FAIL idle_ignore: got rdy=%b b=%b required 0 0", in_ready, busy);
    else pass_cnt++;
    in_valid = 1'b0;
    test_back_to_back(5);
  endtask

  task automatic test_random();
    logic [63:0] s[$];
    int lat;
    int n;
    int gap;
    int sr;
    int si;
    int r;
    int im;
    logic rdy;
    logic [63:0] res;
    logic [63:0] exp_v;
    for (int it = 0; it < 8; it++) begin
      s.delete();
      n   = $urandom_range(40, 1);
      gap = $urandom_range(3, 0);
      sr  = 0;
      si  = 0;
      for (int j = 0; j < n; j++) begin
        r  = int'($urandom_range(2000, 0)) - 1000;
        im = int'($urandom_range(2000, 0)) - 1000;
        sr += r;
        si += im;
        s.push_back({int_to_fp(r), int_to_fp(im)});
      end
      exp_v = {int_to_fp(sr), int_to_fp(si)};
      run_op(s, gap, -1, lat, rdy, res);
      total_cnt++;
      if (res !== exp_v)
        $display("FAIL random_out[%0d] len=%0d gap=%0d: got %h required %h", it, n, gap, res,
                 exp_v);
      else pass_cnt++;
      total_cnt++;
      if (lat !== ExpLat)
        $display("FAIL random_latency[%0d]: got %0d required %0d", it, lat, ExpLat);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero_len();
    test_back_to_back(-1);
    test_gapped();
    test_reset_mid();
    test_ignored();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule
